fpu_norm_arbiter: RTL and testbench
===================================

Name: fpu_norm_arbiter

Overview:
- Shares one 32-bit leading-zero-count and normalize-shift datapath among NREQ FPU requesters, such as the add/sub, int-to-float and mul-align paths.
- Arbitrates requests, registers the winning operand, then computes LZC and left-normalizes in a second registered stage.
- Sits between the FPU execution sub-units and rounding; replaces per-unit normalizers.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester index; must equal clog2(NREQ).

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_data  in  32*NREQ  operand for requester k in bits [32k+31:32k].
- req_ready  out  NREQ  one-hot grant; handshake completes when req_valid[k] and req_ready[k] are both high.
- out_valid  out  1  normalized result valid.
- out_ready  in  1  downstream accept.
- out_id  out  IDW  index of the requester that owns the result.
- out_mant  out  32  operand shifted left by out_lzc; MSB is 1 unless out_zero.
- out_lzc  out  6  leading-zero count, 0..32.
- out_zero  out  1  operand was all zeros.

Behaviour:
- Reset (rst_n low, asynchronous): all outputs are 0; both stage valids clear; RR pointer = 0. Any in-flight data is discarded; no result is produced for it after reset releases.
- Pipeline:
  - S1 holds {s1_valid, s1_id, s1_data}.
  - S2 holds {out_valid, out_id, out_mant, out_lzc, out_zero}.
  - Latency from accepted handshake to out_valid is exactly 2 cycles with no backpressure.
  - Throughput is 1 operand per cycle.
- Stall rules:
  - s2_en = !out_valid | out_ready.
  - s1_en = !s1_valid | s2_en.
  - When s2_en is high, S2 loads from S1: out_valid <= s1_valid.
  - When s1_en is high, S1 loads the granted operand: s1_valid <= any grant.
  - Stalled stages hold all fields unchanged. No bubbles are inserted when out_ready stays high.
- Arbitration (combinational):
  - req_ready is zero when s1_en is low.
  - Otherwise exactly one bit is set: the first valid requester at or after the RR pointer, searching upward with wrap modulo NREQ.
  - req_ready never asserts for a requester whose req_valid is low.
  - req_ready may depend on req_valid; req_valid must not depend on req_ready.
- RR pointer: on any grant, pointer <= granted index + 1, wrapping NREQ-1 -> 0. The pointer is unchanged when there is no grant.
- LZC (S1 -> S2):
  - Count leading zeros from bit 31, built as four byte counters merged from the top byte downward.
  - out_lzc = 32 for a zero operand, otherwise 0..31.
  - out_mant = data << lzc for nonzero operands; 0 when zero.
  - out_zero = (data == 0).
- Simultaneous events:
  - With out_ready high, S2 drains and S1 advances in the same cycle, and a new grant is still issued.
  - A requester may drop req_valid without a grant; it is not treated as a protocol error.
- Holding: output fields are stable while out_valid && !out_ready.

Optional Feature:
- Macro FPU_NORM_RR_EN.
  - Defined: round-robin arbitration as specified above.
  - Undefined: fixed priority, lowest index wins; the RR pointer register is not instantiated.
  - All other timing and handshake behaviour is identical in both builds.

Test Plan:
- Single request, req 2, data 0x0000_1234, out_ready=1 -> 2 cycles later: out_valid=1, out_id=2, out_lzc=19, out_mant=0x91A0_0000, out_zero=0.
- Zero operand, req 0, data 0x0000_0000 -> out_lzc=32, out_mant=0, out_zero=1. Also data 0x8000_0000 -> lzc=0, mant unchanged.
- All 4 requesters valid continuously, out_ready=1, FPU_NORM_RR_EN defined:
  - grants in order 0,1,2,3,0,...; one result per cycle.
  - Same stimulus with the macro undefined -> requester 0 granted every cycle.
- Backpressure: stream 3 operands, hold out_ready=0 for 4 cycles:
  - first result holds stable;
  - S1 fills, then req_ready drops to 0;
  - on release, results arrive in grant order with none lost or duplicated.
- Reset mid-stream: assert rst_n low while S1 and S2 are both valid:
  - out_valid and req_ready go to 0 immediately, without waiting for a clock edge;
  - after release, first grant goes to requester 0;
  - no stale result appears.
- Sweep: for each single-bit operand 1<<k, k=0..31 -> out_lzc=31-k, out_mant=0x8000_0000.

Source files
------------

// File: rtl/fpu_norm_arbiter.sv
// ============================================================================
//  Module      : fpu_norm_arbiter
//  Description : Shared 32-bit leading-zero-count / normalize-shift datapath
//                for NREQ FPU requesters. Stage 1 arbitrates and registers
//                the winning operand; stage 2 computes the LZC and the
//                left-normalized mantissa.
//  Build macro : FPU_NORM_RR_EN - defined selects round-robin arbitration,
//                undefined selects fixed priority (lowest index wins).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_norm_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [IDW-1:0]       out_id,
    output logic [31:0]          out_mant,
    output logic [5:0]           out_lzc,
    output logic                 out_zero
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic            s1_valid_q, s1_valid_d;
    logic [IDW-1:0]  s1_id_q,    s1_id_d;
    logic [31:0]     s1_data_q,  s1_data_d;

    logic            out_valid_q, out_valid_d;
    logic [IDW-1:0]  out_id_q,    out_id_d;
    logic [31:0]     out_mant_q,  out_mant_d;
    logic [5:0]      out_lzc_q,   out_lzc_d;
    logic            out_zero_q,  out_zero_d;

    // ------------------------------------------------------------------
    // Combinational nets
    // ------------------------------------------------------------------
    logic            w_s2_en;
    logic            w_s1_en;
    logic            w_lo_found;
    logic [IDW-1:0]  w_lo_idx;
    logic [IDW-1:0]  w_grant_idx;
    logic            w_grant_any;
    logic [NREQ-1:0] w_grant_vec;
    logic [31:0]     w_sel_data;
    logic [3:0]      w_cnt3, w_cnt2, w_cnt1, w_cnt0;
    logic [5:0]      w_lzc;

`ifdef FPU_NORM_RR_EN
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic            w_hi_found;
    logic [IDW-1:0]  w_hi_idx;
`endif

    // Leading-zero count of one byte: 8 when the byte is zero, else 0..7.
    function automatic logic [3:0] lzc8(input logic [7:0] b);
        logic [3:0] n;
        n = 4'd8;
        // Scan upward so the highest set bit is the last one to write n.
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                n = 4'(7 - i);
            end
        end
        return n;
    endfunction

    // Stage enables: a stage may load when it is empty or its consumer moves.
    always_comb begin
        w_s2_en = !out_valid_q || out_ready;
        w_s1_en = !s1_valid_q  || w_s2_en;
    end

    // Requester search: lowest valid index overall, and (round-robin build)
    // lowest valid index at or above the pointer; the latter wins if found,
    // which is equivalent to a wrapped upward search from the pointer.
    always_comb begin
        w_lo_found = 1'b0;
        w_lo_idx   = '0;
`ifdef FPU_NORM_RR_EN
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
`endif
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[k] && !w_lo_found) begin
                w_lo_found = 1'b1;
                w_lo_idx   = IDW'(k);
            end
`ifdef FPU_NORM_RR_EN
            if (req_valid[k] && !w_hi_found && (k >= int'(ptr_q))) begin
                w_hi_found = 1'b1;
                w_hi_idx   = IDW'(k);
            end
`endif
        end
    end

    // Winner selection, one-hot grant vector and operand mux.
    always_comb begin
`ifdef FPU_NORM_RR_EN
        w_grant_idx = w_hi_found ? w_hi_idx : w_lo_idx;
`else
        w_grant_idx = w_lo_idx;
`endif
        // Gating with rst_n forces the grant low the moment reset asserts.
        w_grant_any = w_s1_en && w_lo_found && rst_n;
        w_grant_vec = '0;
        w_sel_data  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_grant_idx == IDW'(k)) begin
                w_grant_vec[k] = w_grant_any;
                w_sel_data     = req_data[32*k +: 32];
            end
        end
    end

    assign req_ready = w_grant_vec;

    // Per-byte LZC merged from the top byte downward.
    always_comb begin
        w_cnt3 = lzc8(s1_data_q[31:24]);
        w_cnt2 = lzc8(s1_data_q[23:16]);
        w_cnt1 = lzc8(s1_data_q[15:8]);
        w_cnt0 = lzc8(s1_data_q[7:0]);
        if (|s1_data_q[31:24]) begin
            w_lzc = {2'b00, w_cnt3};
        end else if (|s1_data_q[23:16]) begin
            w_lzc = 6'd8 + {2'b00, w_cnt2};
        end else if (|s1_data_q[15:8]) begin
            w_lzc = 6'd16 + {2'b00, w_cnt1};
        end else if (|s1_data_q[7:0]) begin
            w_lzc = 6'd24 + {2'b00, w_cnt0};
        end else begin
            w_lzc = 6'd32;
        end
    end

    // Stage 1 next state: load the granted operand whenever S1 may advance.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_id_d    = s1_id_q;
        s1_data_d  = s1_data_q;
        if (w_s1_en) begin
            s1_valid_d = w_grant_any;
            if (w_grant_any) begin
                s1_id_d   = w_grant_idx;
                s1_data_d = w_sel_data;
            end
        end
    end

    // Stage 2 next state: normalized result; fields hold while stalled.
    always_comb begin
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_mant_d  = out_mant_q;
        out_lzc_d   = out_lzc_q;
        out_zero_d  = out_zero_q;
        if (w_s2_en) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_id_d   = s1_id_q;
                // A shift by 32 of a zero operand yields zero as required.
                out_mant_d = s1_data_q << w_lzc;
                out_lzc_d  = w_lzc;
                out_zero_d = (s1_data_q == 32'd0);
            end
        end
    end

`ifdef FPU_NORM_RR_EN
    // Round-robin pointer advances past the granted index on every grant.
    always_comb begin
        ptr_d = ptr_q;
        if (w_grant_any) begin
            if (w_grant_idx == IDW'(NREQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = w_grant_idx + IDW'(1);
            end
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    // Pipeline registers; reset discards any in-flight operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_id_q     <= '0;
            s1_data_q   <= '0;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_mant_q  <= '0;
            out_lzc_q   <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_id_q     <= s1_id_d;
            s1_data_q   <= s1_data_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_mant_q  <= out_mant_d;
            out_lzc_q   <= out_lzc_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_mant  = out_mant_q;
    assign out_lzc   = out_lzc_q;
    assign out_zero  = out_zero_q;

endmodule

`default_nettype wire

// File: tb/tb_fpu_norm_arbiter.sv
// ============================================================================
//  Module      : tb_fpu_norm_arbiter
//  Description : Directed self-checking bench for fpu_norm_arbiter.
//                Expectations follow FPU_NORM_RR_EN when it is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpu_norm_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_id;
    logic [31:0]  out_mant;
    logic [5:0]   out_lzc;
    logic         out_zero;

    int checks = 0;
    int errors = 0;

    fpu_norm_arbiter #(.NREQ(4), .IDW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_mant  (out_mant),
        .out_lzc   (out_lzc),
        .out_zero  (out_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pulse reset with no requests; returns at a falling edge.
    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present one operand for one cycle; returns at the falling edge two
    // cycles after the handshake edge, where the result is visible.
    task automatic drive_one(input int id, input logic [31:0] d);
        logic [3:0] v;
        v = '0;
        v[id] = 1'b1;
        req_valid = v;
        req_data[32*id +: 32] = d;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        out_ready = 1'b1;
        req_valid = 4'hF;
        req_data  = '0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL reset_req_ready: got %b expected 0000", req_ready);
        end
        checks++;
        if ({out_id, out_mant, out_lzc, out_zero} !== 41'd0) begin
            errors++; $display("FAIL reset_fields: got id=%0d mant=%h lzc=%0d zero=%b expected all 0",
                               out_id, out_mant, out_lzc, out_zero);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        drive_one(2, 32'h0000_1234);
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd2) begin
            errors++; $display("FAIL single_valid_id: got valid=%b id=%0d expected 1/2", out_valid, out_id);
        end
        checks++;
        if (out_lzc !== 6'd19 || out_mant !== 32'h91A0_0000 || out_zero !== 1'b0) begin
            errors++; $display("FAIL single_result: got lzc=%0d mant=%h zero=%b expected 19/91a00000/0",
                               out_lzc, out_mant, out_zero);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL single_drain: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_zero_msb();
        drive_one(0, 32'h0000_0000);
        checks++;
        if (out_valid !== 1'b1 || out_lzc !== 6'd32 || out_mant !== 32'd0 || out_zero !== 1'b1) begin
            errors++; $display("FAIL zero_operand: got v=%b lzc=%0d mant=%h zero=%b expected 1/32/0/1",
                               out_valid, out_lzc, out_mant, out_zero);
        end
        @(negedge clk);
        drive_one(0, 32'h8000_0000);
        checks++;
        if (out_valid !== 1'b1 || out_lzc !== 6'd0 || out_mant !== 32'h8000_0000 || out_zero !== 1'b0) begin
            errors++; $display("FAIL msb_operand: got v=%b lzc=%0d mant=%h zero=%b expected 1/0/80000000/0",
                               out_valid, out_lzc, out_mant, out_zero);
        end
        @(negedge clk);
    endtask

    task automatic test_sweep();
        logic [31:0] d;
        for (int k = 0; k < 32; k++) begin
            d = 32'h1 << k;
            drive_one(k % 4, d);
            checks++;
            if (out_valid !== 1'b1 || out_lzc !== 6'(31 - k) || out_mant !== 32'h8000_0000
                || out_id !== 2'(k % 4)) begin
                errors++; $display("FAIL sweep_bit%0d: got v=%b id=%0d lzc=%0d mant=%h expected 1/%0d/%0d/80000000",
                                   k, out_valid, out_id, out_lzc, out_mant, k % 4, 31 - k);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_all_valid();
        logic [3:0] exp_g;
        int         exp_id;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            req_data[32*k +: 32] = 32'h1 << (8 * k);
        end
        out_ready = 1'b1;
        req_valid = 4'hF;
        for (int c = 0; c < 8; c++) begin
            #1;
`ifdef FPU_NORM_RR_EN
            exp_g  = 4'b0001 << (c % 4);
            exp_id = (c + 2) % 4;
`else
            exp_g  = 4'b0001;
            exp_id = 0;
`endif
            checks++;
            if (req_ready !== exp_g) begin
                errors++; $display("FAIL all_valid_grant c%0d: got %b expected %b", c, req_ready, exp_g);
            end
            if (c >= 2) begin
                checks++;
                if (out_valid !== 1'b1 || out_id !== 2'(exp_id) || out_lzc !== 6'(31 - 8 * exp_id)) begin
                    errors++; $display("FAIL all_valid_result c%0d: got v=%b id=%0d lzc=%0d expected 1/%0d/%0d",
                                       c, out_valid, out_id, out_lzc, exp_id, 31 - 8 * exp_id);
                end
            end
            @(negedge clk);
        end
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        req_valid = 4'b0010;
        req_data[63:32] = 32'h00F0_0000;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_grant_a: got %b expected 0010", req_ready);
        end
        @(negedge clk);
        req_data[63:32] = 32'h0000_0003;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_grant_b: got %b expected 0010", req_ready);
        end
        @(negedge clk);
        req_data[63:32] = 32'h4000_0000;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000) begin
                errors++; $display("FAIL bp_ready_low c%0d: got %b expected 0000", c, req_ready);
            end
            checks++;
            if (out_valid !== 1'b1 || out_id !== 2'd1 || out_lzc !== 6'd8 || out_mant !== 32'hF000_0000) begin
                errors++; $display("FAIL bp_hold c%0d: got v=%b id=%0d lzc=%0d mant=%h expected 1/1/8/f0000000",
                                   c, out_valid, out_id, out_lzc, out_mant);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_release_grant: got %b expected 0010", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        checks++;
        if (out_valid !== 1'b1 || out_lzc !== 6'd30 || out_mant !== 32'hC000_0000) begin
            errors++; $display("FAIL bp_second: got v=%b lzc=%0d mant=%h expected 1/30/c0000000",
                               out_valid, out_lzc, out_mant);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_lzc !== 6'd1 || out_mant !== 32'h8000_0000) begin
            errors++; $display("FAIL bp_third: got v=%b lzc=%0d mant=%h expected 1/1/80000000",
                               out_valid, out_lzc, out_mant);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_no_duplicate: got valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        req_data[127:96] = 32'h0000_00FF;
        req_data[31:0]   = 32'h0000_0100;
        req_valid = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        req_valid = 4'b1001;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd3) begin
            errors++; $display("FAIL mid_precondition: got v=%b id=%0d expected 1/3", out_valid, out_id);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || req_ready !== 4'b0000) begin
            errors++; $display("FAIL mid_async_reset: got v=%b ready=%b expected 0/0000", out_valid, req_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL mid_first_grant: got %b expected 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_no_stale: got valid=%b expected 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_id !== 2'd0 || out_lzc !== 6'd23 || out_mant !== 32'h8000_0000) begin
            errors++; $display("FAIL mid_new_result: got v=%b id=%0d lzc=%0d mant=%h expected 1/0/23/80000000",
                               out_valid, out_id, out_lzc, out_mant);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL mid_drain: got valid=%b expected 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_msb();
        test_sweep();
        test_all_valid();
        test_backpressure();
        test_reset_midstream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
